// File: rtl/shared_bus_arb_pkg.sv
// Shared types and helpers for the round-robin shared-bus arbiter.
package shared_bus_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN, TURN} arb_state_t;

  // Owner index width: at least one bit, even for a single requester.
  function automatic int unsigned owner_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_pick.sv
// Combinational wrapping first-set search starting at rr_ptr.
module rr_pick
  import shared_bus_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned OW = owner_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   rr_ptr,
  output logic            found,
  output logic [OW-1:0]   idx
);

  always_comb begin
    int unsigned j;
    logic [OW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j    = (32'(rr_ptr) + i) % NREQ;
      cand = OW'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner arbiter for a shared bus with a one-cycle turnaround.
// Optional forced release after MAX_HOLD cycles: define SHARED_BUS_HOLD_TIMEOUT_EN.
module shared_bus_arbiter
  import shared_bus_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned OW = owner_w(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    last,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               bus_valid,
  output logic [DW-1:0]      bus_data,
  output logic [OW-1:0]      bus_owner
);

  arb_state_t      state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic            valid_n;
  logic [DW-1:0]   data_n;
  logic [OW-1:0]   owner_n;
  logic [OW-1:0]   rr_ptr, ptr_n;
  logic            pick_found;
  logic [OW-1:0]   pick_idx;
  logic [DW-1:0]   owner_data;
  logic            release_c;

`ifdef SHARED_BUS_HOLD_TIMEOUT_EN
  localparam int unsigned HW = owner_w(MAX_HOLD);
  logic [HW-1:0] hold_cnt, hold_n;
`endif

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Owner's data lane; constant part-selects keep the mux lint-clean.
  always_comb begin
    owner_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (OW'(i) == bus_owner) owner_data = wdata[i*DW +: DW];
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    valid_n   = 1'b0;
    data_n    = bus_data;
    owner_n   = bus_owner;
    ptr_n     = rr_ptr;
    release_c = 1'b0;
`ifdef SHARED_BUS_HOLD_TIMEOUT_EN
    hold_n    = hold_cnt;
`endif
    case (state)
      IDLE, TURN: begin
        if (pick_found) begin
          state_n = OWN;
          gnt_n   = NREQ'(1) << pick_idx;
          owner_n = pick_idx;
`ifdef SHARED_BUS_HOLD_TIMEOUT_EN
          hold_n  = '0;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      OWN: begin
        // The final beat (last or timeout) is still transferred on release.
        data_n    = owner_data;
        valid_n   = req[bus_owner];
        release_c = !req[bus_owner] || last[bus_owner];
`ifdef SHARED_BUS_HOLD_TIMEOUT_EN
        hold_n = hold_cnt + 1'b1;
        if (hold_cnt == HW'(MAX_HOLD - 1)) release_c = 1'b1;
`endif
        if (release_c) begin
          state_n = TURN;
          gnt_n   = '0;
          ptr_n   = (bus_owner == OW'(NREQ - 1)) ? '0 : bus_owner + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      bus_valid <= 1'b0;
      bus_data  <= '0;
      bus_owner <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      bus_valid <= valid_n;
      bus_data  <= data_n;
      bus_owner <= owner_n;
      rr_ptr    <= ptr_n;
    end
  end

`ifdef SHARED_BUS_HOLD_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_cnt <= '0;
    else       hold_cnt <= hold_n;
  end
`endif

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter (NREQ=4, DW=32, MAX_HOLD=8).
module tb_shared_bus_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 32;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    last;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic               bus_valid;
  logic [DW-1:0]      bus_data;
  logic [1:0]         bus_owner;

  int n_checks = 0;
  int n_errors = 0;
  logic [NREQ-1:0] prev_gnt = '0;

  shared_bus_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .wdata     (wdata),
    .gnt       (gnt),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_owner (bus_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int unsigned i, input logic [DW-1:0] v);
    wdata[i*DW +: DW] = v;
  endtask

  // Continuous invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_gnt = '0;
    end else begin
      check("onehot0_gnt", 64'($onehot0(gnt)), 64'd1);
      if (bus_valid) check("valid_had_gnt", 64'(prev_gnt[bus_owner]), 64'd1);
      prev_gnt = gnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int cnt;
    reset = 1'b1;
    req   = '0;
    last  = '0;
    wdata = '0;
    step();
    step();
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_valid", 64'(bus_valid), 64'h0);
    check("rst_owner", 64'(bus_owner), 64'h0);
    check("rst_data", 64'(bus_data), 64'h0);
    reset = 1'b0;

    // Single owner: req[2] from cycle 0.
    req = 4'b0100;
    step();
    check("s_gnt", 64'(gnt), 64'h4);
    check("s_owner", 64'(bus_owner), 64'h2);
    check("s_valid0", 64'(bus_valid), 64'h0);
    set_lane(2, 32'hA5A5_0001);
    step();
    check("s_data1", 64'(bus_data), 64'hA5A5_0001);
    check("s_valid1", 64'(bus_valid), 64'h1);
    set_lane(2, 32'hA5A5_0002);
    step();
    check("s_data2", 64'(bus_data), 64'hA5A5_0002);
    set_lane(2, 32'hA5A5_0003);
    last = 4'b0100;
    step();
    check("s_rel_gnt", 64'(gnt), 64'h0);
    check("s_last_valid", 64'(bus_valid), 64'h1);
    check("s_last_data", 64'(bus_data), 64'hA5A5_0003);
    req  = '0;
    last = '0;
    step();
    check("s_idle_gnt", 64'(gnt), 64'h0);
    check("s_idle_valid", 64'(bus_valid), 64'h0);
    check("s_idle_owner", 64'(bus_owner), 64'h2);

    // rr_ptr is now 3; 0011 wraps to owner 0, then reset mid-ownership.
    req = 4'b0011;
    step();
    check("r_gnt", 64'(gnt), 64'h1);
    check("r_owner", 64'(bus_owner), 64'h0);
    step();
    check("r_valid", 64'(bus_valid), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("r_async_gnt", 64'(gnt), 64'h0);
    check("r_async_valid", 64'(bus_valid), 64'h0);
    check("r_async_owner", 64'(bus_owner), 64'h0);
    check("r_async_data", 64'(bus_data), 64'h0);
    req = '0;
    step();
    reset = 1'b0;

    // Round robin with all requesting; last after two beats.
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      check("rr_gnt", 64'(gnt), 64'(1 << order[k]));
      check("rr_owner", 64'(bus_owner), 64'(order[k]));
      step();
      check("rr_beat", 64'(bus_valid), 64'h1);
      last = 4'(1 << order[k]);
      step();
      check("rr_turn", 64'(gnt), 64'h0);
      last = '0;
      step();
    end
    // Owner 1 now granted; dropping its req releases, TURN picks 3.
    check("w_gnt1", 64'(gnt), 64'h2);
    req = 4'b1000;
    step();
    check("w_rel1", 64'(gnt), 64'h0);
    check("w_rel1_valid", 64'(bus_valid), 64'h0);
    step();
    check("w_gnt3", 64'(gnt), 64'h8);
    // Owner 3 releases while req0 arrives: pointer wraps to 0.
    req  = 4'b1001;
    last = 4'b1000;
    step();
    check("w_rel3", 64'(gnt), 64'h0);
    last = '0;
    step();
    check("w_wrap_gnt0", 64'(gnt), 64'h1);
    check("w_wrap_owner", 64'(bus_owner), 64'h0);
    req = '0;
    step();
    check("w_rel0", 64'(gnt), 64'h0);
    step();
    check("w_idle", 64'(gnt), 64'h0);

    // Hold behaviour: req[1] held with last=0 (rr_ptr=1).
    set_lane(1, 32'h1111_2222);
    req = 4'b0010;
    step();
    check("t_gnt", 64'(gnt), 64'h2);
    cnt = 1;
    while (cnt < 150) begin
      step();
      if (gnt != 4'b0010) break;
      cnt++;
    end
`ifdef SHARED_BUS_HOLD_TIMEOUT_EN
    check("t_hold_len", 64'(cnt), 64'd8);
    check("t_turn", 64'(gnt), 64'h0);
    check("t_last_valid", 64'(bus_valid), 64'h1);
    step();
    check("t_regrant", 64'(gnt), 64'h2);
`else
    check("t_hold_len", 64'(cnt), 64'd150);
    check("t_still_gnt", 64'(gnt), 64'h2);
    check("t_data", 64'(bus_data), 64'h1111_2222);
`endif
    req = '0;
    step();
    step();
    step();
    check("end_gnt", 64'(gnt), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
